// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - decode-to-scheduler instruction pair handshake.
// Slot 0 is the older instruction of the pair.
interface issue_scheduler_if #(
  parameter int REG_ADDR_WIDTH = 7,
  parameter int WORD           = 32,
  parameter int LAT_WIDTH      = 4
);
  logic                        pair_valid;
  logic                        pair_ready;
  logic [WORD-1:0]             in0_instr,  in1_instr;
  logic                        in0_pipe,   in1_pipe;
  logic [LAT_WIDTH-1:0]        in0_lat,    in1_lat;
  logic [REG_ADDR_WIDTH-1:0]   in0_rt,     in1_rt;
  logic                        in0_rt_we,  in1_rt_we;
  logic [3*REG_ADDR_WIDTH-1:0] in0_src,    in1_src;
  logic [2:0]                  in0_src_en, in1_src_en;
  logic                        in0_branch, in1_branch;

  modport master (
    output pair_valid,
    output in0_instr, in0_pipe, in0_lat, in0_rt, in0_rt_we, in0_src, in0_src_en, in0_branch,
    output in1_instr, in1_pipe, in1_lat, in1_rt, in1_rt_we, in1_src, in1_src_en, in1_branch,
    input  pair_ready
  );

  modport slave (
    input  pair_valid,
    input  in0_instr, in0_pipe, in0_lat, in0_rt, in0_rt_we, in0_src, in0_src_en, in0_branch,
    input  in1_instr, in1_pipe, in1_lat, in1_rt, in1_rt_we, in1_src, in1_src_en, in1_branch,
    output pair_ready
  );
endinterface

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - SPU dual-issue scheduler: pair buffer, scoreboard, even/odd routing.
// Outputs are registered; issue decisions use only buffered slots and scoreboard state.
module issue_scheduler #(
  parameter int              REG_ADDR_WIDTH = 7,
  parameter int              WORD           = 32,
  parameter int              LAT_WIDTH      = 4,
  parameter logic [WORD-1:0] NOP_WORD       = 32'h4020_0000,
  parameter logic [WORD-1:0] LNOP_WORD      = 32'h0020_0000
) (
  input  logic                clk,
  input  logic                reset,
  issue_scheduler_if.slave    dec,
  input  logic                flush,
  output logic                even_valid,
  output logic [WORD-1:0]     even_instr,
  output logic                odd_valid,
  output logic [WORD-1:0]     odd_instr,
  output logic                br_first_instr,
  output logic [31:0]         dual_count
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam int R    = REG_ADDR_WIDTH;

  typedef enum logic [1:0] {EMPTY, FULL, HALF} state_e;

  typedef struct packed {
    logic [WORD-1:0]      instr;
    logic                 pipe;
    logic [LAT_WIDTH-1:0] lat;
    logic [R-1:0]         rt;
    logic                 rt_we;
    logic [3*R-1:0]       src;
    logic [2:0]           src_en;
    logic                 branch;
  } slot_t;

  state_e               state_q, state_d;
  slot_t                s0_q, s0_d, s1_q, s1_d, new0, new1;
  logic [LAT_WIDTH-1:0] sb_q [NREG];
  logic [LAT_WIDTH-1:0] sb_d [NREG];
  logic                 even_valid_q, even_valid_d, odd_valid_q, odd_valid_d;
  logic [WORD-1:0]      even_instr_q, even_instr_d, odd_instr_q, odd_instr_d;
  logic                 br_q, br_d;
  logic [31:0]          dual_count_q, dual_count_d;
  logic                 s0_clear, s1_clear, dual_ok, iss0, iss1, pair_ready, accept;
  logic                 odd_is_branch;

  // Latency 0 behaves as 1, so the loaded countdown is max(lat,1)-1.
  function automatic logic [LAT_WIDTH-1:0] ld_val(input logic [LAT_WIDTH-1:0] lat);
    return (lat == '0) ? '0 : lat - LAT_WIDTH'(1);
  endfunction

  function automatic logic reads_reg(input slot_t s, input logic [R-1:0] r);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 3; k++)
      if (s.src_en[k] && (s.src[k*R +: R] == r)) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic slot_clear(input slot_t s);
    logic hz;
    hz = s.rt_we && (sb_q[s.rt] > ld_val(s.lat));
    for (int k = 0; k < 3; k++)
      if (s.src_en[k] && (sb_q[s.src[k*R +: R]] != '0)) hz = 1'b1;
    return !hz;
  endfunction

  always_comb begin
    new0 = '{instr: dec.in0_instr, pipe: dec.in0_pipe, lat: dec.in0_lat, rt: dec.in0_rt,
             rt_we: dec.in0_rt_we, src: dec.in0_src, src_en: dec.in0_src_en, branch: dec.in0_branch};
    new1 = '{instr: dec.in1_instr, pipe: dec.in1_pipe, lat: dec.in1_lat, rt: dec.in1_rt,
             rt_we: dec.in1_rt_we, src: dec.in1_src, src_en: dec.in1_src_en, branch: dec.in1_branch};
  end

  always_comb begin
    s0_clear = slot_clear(s0_q);
    s1_clear = slot_clear(s1_q);
    dual_ok  = s0_clear && s1_clear && (s0_q.pipe != s1_q.pipe)
               && !(s0_q.rt_we && reads_reg(s1_q, s0_q.rt))
               && !(s0_q.rt_we && s1_q.rt_we && (s0_q.rt == s1_q.rt));
    iss0 = 1'b0;
    iss1 = 1'b0;
    case (state_q)
      FULL: begin
        if (dual_ok) begin
          iss0 = 1'b1;
          iss1 = 1'b1;
        end else if (s0_clear) begin
          iss0 = 1'b1;
        end
      end
      HALF:    iss1 = s1_clear;
      default: ;
    endcase
    if (flush) begin
      iss0 = 1'b0;
      iss1 = 1'b0;
    end
    pair_ready = !flush && ((state_q == EMPTY) || ((state_q == FULL) && iss0 && iss1)
                            || ((state_q == HALF) && iss1));
    accept = dec.pair_valid && pair_ready;

    state_d = state_q;
    if (accept)                                  state_d = FULL;
    else if (flush)                              state_d = EMPTY;
    else if (iss1)                               state_d = EMPTY;
    else if ((state_q == FULL) && iss0)          state_d = HALF;
    s0_d = accept ? new0 : s0_q;
    s1_d = accept ? new1 : s1_q;

    even_valid_d = (iss0 && !s0_q.pipe) || (iss1 && !s1_q.pipe);
    odd_valid_d  = (iss0 &&  s0_q.pipe) || (iss1 &&  s1_q.pipe);
    even_instr_d = (iss0 && !s0_q.pipe) ? s0_q.instr : (iss1 && !s1_q.pipe) ? s1_q.instr : NOP_WORD;
    odd_instr_d  = (iss0 &&  s0_q.pipe) ? s0_q.instr : (iss1 &&  s1_q.pipe) ? s1_q.instr : LNOP_WORD;
    // Branch flag only when the odd-pipe instruction is slot 0's branch in a dual issue.
    odd_is_branch = s0_q.pipe ? s0_q.branch : s1_q.branch;
    br_d          = iss0 && iss1 && s0_q.pipe && odd_is_branch;
    dual_count_d  = (iss0 && iss1) ? dual_count_q + 32'd1 : dual_count_q;
  end

  // Loads from issuing slots take priority over the per-edge countdown.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - LAT_WIDTH'(1) : '0;
      if (iss0 && s0_q.rt_we && (s0_q.rt == R'(r))) sb_d[r] = ld_val(s0_q.lat);
      if (iss1 && s1_q.rt_we && (s1_q.rt == R'(r))) sb_d[r] = ld_val(s1_q.lat);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      s0_q         <= '0;
      s1_q         <= '0;
      even_valid_q <= 1'b0;
      odd_valid_q  <= 1'b0;
      even_instr_q <= NOP_WORD;
      odd_instr_q  <= LNOP_WORD;
      br_q         <= 1'b0;
      dual_count_q <= '0;
      for (int i = 0; i < NREG; i++) sb_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      even_valid_q <= even_valid_d;
      odd_valid_q  <= odd_valid_d;
      even_instr_q <= even_instr_d;
      odd_instr_q  <= odd_instr_d;
      br_q         <= br_d;
      dual_count_q <= dual_count_d;
      for (int i = 0; i < NREG; i++) sb_q[i] <= sb_d[i];
    end
  end

  assign dec.pair_ready   = pair_ready;
  assign even_valid       = even_valid_q;
  assign odd_valid        = odd_valid_q;
  assign even_instr       = even_instr_q;
  assign odd_instr        = odd_instr_q;
  assign br_first_instr   = br_q;
  assign dual_count       = dual_count_q;
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Dual-issue front end for the SPU. Accepts one in-order instruction pair per handshake from decode and routes each instruction to the even or odd pipe.
- Holds a per-register scoreboard and stalls or splits the pair on structural, RAW and WAW hazards.
- Sits between decode and the register-file read stage of spuMainModule. Drives br_first_instr to the odd pipe and accepts a branch flush back from it.

Parameters:
- REG_ADDR_WIDTH, 7: register address width (128 registers).
- WORD, 32: instruction word width.
- LAT_WIDTH, 4: latency field width.
- NOP_WORD, 32'h4020_0000: even-pipe filler emitted when the even pipe is idle.
- LNOP_WORD, 32'h0020_0000: odd-pipe filler emitted when the odd pipe is idle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pair_valid  in  1  decode offers a pair.
- pair_ready  out  1  scheduler accepts the pair this cycle.
- in0_instr  in  WORD  slot 0 (older) instruction word.
- in0_pipe  in  1  0 = even pipe, 1 = odd pipe.
- in0_lat  in  LAT_WIDTH  result latency in cycles; 0 is treated as 1.
- in0_rt  in  REG_ADDR_WIDTH  destination register.
- in0_rt_we  in  1  instruction writes in0_rt.
- in0_src  in  3*REG_ADDR_WIDTH  packed {ra, rb, rc}.
- in0_src_en  in  3  per-source read enable, bit order {ra, rb, rc}.
- in0_branch  in  1  instruction is a branch (odd pipe).
- in1_instr/in1_pipe/in1_lat/in1_rt/in1_rt_we/in1_src/in1_src_en/in1_branch  in  same widths as in0_*  slot 1 (younger).
- flush  in  1  branch taken, from odd pipe.
- even_valid  out  1  even pipe receives a real instruction.
- even_instr  out  WORD  even-pipe instruction word; NOP_WORD when even_valid=0.
- odd_valid  out  1  odd pipe receives a real instruction.
- odd_instr  out  WORD  odd-pipe instruction word; LNOP_WORD when odd_valid=0.
- br_first_instr  out  1  odd instruction is a branch from slot 0 dual-issued with an even slot-1 instruction.
- dual_count  out  32  number of dual-issue events.

Behaviour:
- Reset: state=EMPTY, all 128 scoreboard counters 0, even_valid=odd_valid=br_first_instr=0, even_instr=NOP_WORD, odd_instr=LNOP_WORD, dual_count=0. Reset mid-operation discards the buffered pair.
- Pair buffer states:
  - EMPTY: no buffered pair.
  - FULL: both slots pending.
  - HALF: slot 1 only pending.
- Accept: pair latched at the edge where pair_valid && pair_ready. pair_ready = (EMPTY) || (FULL and both slots issue this cycle) || (HALF and slot 1 issues this cycle). pair_ready is combinational from the buffer and scoreboard state, never from pair_valid.
- Issue decisions are evaluated on buffered contents; outputs are registered. The earliest issue is the edge after accept.
- Hazard test for a slot:
  - RAW: any enabled source s has sb[s] != 0.
  - WAW vs in-flight: rt_we && sb[rt] > max(lat,1)-1.
  - A slot is clear if neither applies.
- FULL cycle:
  - Dual issue iff both slots are clear, pipes differ, slot 1 does not read slot 0's rt while in0_rt_we, and the pair is not a same-rt double write. Both outputs are driven; state goes to EMPTY or to FULL if a new pair is accepted.
  - Otherwise, if slot 0 is clear: issue slot 0 alone, go to HALF.
  - Otherwise: stall, nothing issued, state unchanged.
- HALF cycle: slot 1 issues when clear, then EMPTY or FULL; otherwise stall.
- Scoreboard:
  - On each issue with rt_we: sb[rt] <= max(lat,1)-1.
  - Every other nonzero entry decrements by 1 per edge.
  - A load wins over a decrement on the same entry at the same edge.
  - Result: a consumer issues no earlier than L edges after its producer (L=1 allows back-to-back issue).
- br_first_instr = 1 on the edge slot 0 branch and slot 1 dual-issue. Otherwise 0.
- flush:
  - At the edge flush=1: state goes to EMPTY, the edge issues nothing (valids 0, fillers driven), and there is no scoreboard load that edge.
  - pair_ready=0 during the flush cycle.
  - Existing scoreboard entries continue counting down; they are not cleared.
- dual_count increments on each dual issue and wraps at 2^32.

Test Plan:
- Reset low, then release; pair in0 even ADD (rt=5, lat=2), in1 odd shift (src ra=9) -> at the next edge even_valid=odd_valid=1, dual_count=1, sb[5]=1, pair_ready stays 1.
- Pair in0 even rt=3 lat=6, in1 odd src ra=3 -> slot 0 issues alone, odd_instr=LNOP_WORD, state HALF, pair_ready=0. Slot 1 issues exactly 6 edges after slot 0.
- Both slots even (in0_pipe=in1_pipe=0, no dependency) -> two consecutive single issues on the even pipe, odd_valid=0 both edges, dual_count unchanged.
- in0 odd branch, in1 even rt=8 -> dual issue with br_first_instr=1. flush=1 at the next edge with a pair pending -> nothing issued that edge, state EMPTY, sb[8] continues counting down.
- Producer rt=10 lat=7 in flight, then pair with in0 even writing rt=10 lat=2 -> stalls until sb[10] <= 1, then issues. sb[10] reloads to 1.
- Assert reset while in HALF with sb entries nonzero -> all outputs return to reset values immediately (asynchronous), pair dropped, all sb entries 0.
